// File: rtl/sel_gate_pipe_if.sv
// Stream bundle for sel_gate_pipe: channel/operand input beats and result output beats.
// The master modport is the side that sources input beats and sinks results.
interface sel_gate_pipe_if #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int SELW = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [N*W-1:0]  in_ch;
  logic [SELW-1:0] in_sel;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_err;

  modport master (
    output in_valid, in_a, in_ch, in_sel, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_a, in_ch, in_sel, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/sel_gate_pipe.sv
// Two-stage select-and-gate pipeline: stage 1 registers the selected channel,
// stage 2 combines it with the operand under the per-beat mode.
module sel_gate_pipe #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int SELW = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  sel_gate_pipe_if.slave  bus,
  input  logic            err_clr,
  output logic            sel_err,
  output logic [CNTW-1:0] beat_cnt
);

  localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

  logic [W-1:0]    s1_a_r;
  logic [W-1:0]    s1_rg_r;
  logic [1:0]      s1_mode_r;
  logic            s1_err_r;
  logic            s1_v_r;
  logic [W-1:0]    out_data_r;
  logic            out_err_r;
  logic            out_valid_r;
  logic            sel_err_r;
  logic [CNTW-1:0] beat_cnt_r;

  logic            s2_free_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            advance_s;
  logic            out_hs_s;
  logic            sel_bad_s;
  logic [W-1:0]    sel_ch_s;
  logic [W-1:0]    op_res_s;

  assign s2_free_s  = !out_valid_r || bus.out_ready;
  assign in_ready_s = !s1_v_r || s2_free_s;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign advance_s  = s1_v_r && s2_free_s;
  assign out_hs_s   = out_valid_r && bus.out_ready;
  // Always false when every select code maps to a channel.
  assign sel_bad_s  = ({1'b0, bus.in_sel} >= N_EXT);

  // Channel mux; out-of-range selects yield zero.
  always_comb begin
    sel_ch_s = '0;
    for (int k = 0; k < N; k++) begin
      if ({1'b0, bus.in_sel} == (SELW+1)'(k)) begin
        sel_ch_s = bus.in_ch[k*W +: W];
      end else begin
        sel_ch_s = sel_ch_s;
      end
    end
  end

  // Per-beat bitwise combine of operand and registered channel.
  always_comb begin
    op_res_s = '0;
    case (s1_mode_r)
      2'b00:   op_res_s = s1_a_r & s1_rg_r;
      2'b01:   op_res_s = s1_a_r | s1_rg_r;
      2'b10:   op_res_s = s1_a_r ^ s1_rg_r;
      2'b11:   op_res_s = s1_rg_r;
      default: op_res_s = '0;
    endcase
  end

  // Stage 1: capture on accept, empty when drained with nothing new arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_r    <= '0;
      s1_rg_r   <= '0;
      s1_mode_r <= 2'b00;
      s1_err_r  <= 1'b0;
      s1_v_r    <= 1'b0;
    end else if (accept_s) begin
      s1_a_r    <= bus.in_a;
      s1_rg_r   <= sel_ch_s;
      s1_mode_r <= bus.in_mode;
      s1_err_r  <= sel_bad_s;
      s1_v_r    <= 1'b1;
    end else if (advance_s) begin
      s1_v_r    <= 1'b0;
    end
  end

  // Stage 2: result register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (advance_s) begin
      out_data_r  <= op_res_s;
      out_err_r   <= s1_err_r;
      out_valid_r <= 1'b1;
    end else if (out_hs_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky select error (set beats clear) and delivered-beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r  <= 1'b0;
      beat_cnt_r <= '0;
    end else begin
      if (accept_s && sel_bad_s) begin
        sel_err_r <= 1'b1;
      end else if (err_clr) begin
        sel_err_r <= 1'b0;
      end
      if (out_hs_s) begin
        beat_cnt_r <= beat_cnt_r + CNTW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_err   = out_err_r;
  assign sel_err       = sel_err_r;
  assign beat_cnt      = beat_cnt_r;

endmodule

// File: tb/tb_sel_gate_pipe.sv
// Directed bench for sel_gate_pipe (W=8, N=3, SELW=2, CNTW=4) with a beat scoreboard.
module tb_sel_gate_pipe;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic       sel_err;
  logic [3:0] beat_cnt;
  int         checks;
  int         errors;
  exp_t       exp_q[$];

  sel_gate_pipe_if #(.W(8), .N(3), .SELW(2)) bus ();

  sel_gate_pipe #(.W(8), .N(3), .SELW(2), .CNTW(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err_clr  (err_clr),
    .sel_err  (sel_err),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [7:0] a, input logic [23:0] ch,
                                 input logic [1:0] sel, input logic [1:0] mode);
    exp_t       r;
    logic [7:0] rg;
    rg    = 8'h00;
    r.err = (sel == 2'd3);
    if (sel == 2'd0)      rg = ch[7:0];
    else if (sel == 2'd1) rg = ch[15:8];
    else if (sel == 2'd2) rg = ch[23:16];
    case (mode)
      2'b00:   r.data = a & rg;
      2'b01:   r.data = a | rg;
      2'b10:   r.data = a ^ rg;
      default: r.data = rg;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [23:0] ch,
                       input logic [1:0] sel, input logic [1:0] mode);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_ch    = ch;
    bus.in_sel   = sel;
    bus.in_mode  = mode;
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_data", 32'(bus.out_data), 32'(e.data));
          check("sb_err", 32'(bus.out_err), 32'(e.err));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_a, bus.in_ch, bus.in_sel, bus.in_mode));
    end
  end

  localparam logic [23:0] CH = 24'h3C_3C_11;

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b1;
    err_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_ch     = 24'h0;
    bus.in_sel    = 2'd0;
    bus.in_mode   = 2'd0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h00);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single AND beat through sel 2.
    drive(8'hF0, CH, 2'd2, 2'b00);
    step();
    bus.in_valid = 1'b0;
    step();
    check("and_valid", 32'(bus.out_valid), 32'd1);
    check("and_data", 32'(bus.out_data), 32'h30);
    check("and_err", 32'(bus.out_err), 32'd0);
    step();
    check("and_cnt", 32'(beat_cnt), 32'd1);
    check("and_drained", 32'(bus.out_valid), 32'd0);

    // Back-to-back OR / XOR / PASS on sel 1.
    drive(8'hF0, CH, 2'd1, 2'b01);
    step();
    drive(8'hF0, CH, 2'd1, 2'b10);
    step();
    check("or_data", 32'(bus.out_data), 32'hFC);
    drive(8'hF0, CH, 2'd1, 2'b11);
    step();
    check("xor_data", 32'(bus.out_data), 32'hCC);
    check("xor_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    step();
    check("pass_data", 32'(bus.out_data), 32'h3C);
    check("pass_valid", 32'(bus.out_valid), 32'd1);
    step();
    check("b2b_drained", 32'(bus.out_valid), 32'd0);
    check("b2b_cnt", 32'(beat_cnt), 32'd4);

    // Out-of-range select and sticky error handling.
    drive(8'h55, CH, 2'd3, 2'b11);
    step();
    bus.in_valid = 1'b0;
    check("bad_sel_err_set", 32'(sel_err), 32'd1);
    step();
    check("bad_data", 32'(bus.out_data), 32'h00);
    check("bad_out_err", 32'(bus.out_err), 32'd1);
    step();
    check("bad_sel_err_sticky", 32'(sel_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_alone", 32'(sel_err), 32'd0);
    err_clr = 1'b1;
    drive(8'h12, CH, 2'd3, 2'b00);
    step();
    err_clr = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_vs_set", 32'(sel_err), 32'd1);
    step();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_cnt", 32'(beat_cnt), 32'd6);

    // Five-cycle stall with three offered beats.
    bus.out_ready = 1'b0;
    drive(8'h0F, CH, 2'd0, 2'b10);
    step();
    check("stall_rdy1", 32'(bus.in_ready), 32'd1);
    drive(8'hAA, CH, 2'd1, 2'b00);
    step();
    check("stall_full", 32'(bus.in_ready), 32'd0);
    check("stall_data0", 32'(bus.out_data), 32'h1E);
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom), 24'($urandom), 2'($urandom), 2'($urandom));
      step();
      check("stall_ready", 32'(bus.in_ready), 32'd0);
      check("stall_hold", 32'(bus.out_data), 32'h1E);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
    end
    drive(8'h0F, CH, 2'd2, 2'b01);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("rel_b", 32'(bus.out_data), 32'h28);
    step();
    check("rel_c", 32'(bus.out_data), 32'h3F);
    step();
    check("rel_drained", 32'(bus.out_valid), 32'd0);
    check("rel_cnt", 32'(beat_cnt), 32'd9);
    check("rel_sb_empty", 32'(exp_q.size()), 32'd0);

    // Eight more streamed beats: seventeen handshakes wrap the 4-bit counter.
    for (int i = 0; i < 8; i++) begin
      drive(8'($urandom), 24'($urandom), 2'($urandom), 2'($urandom));
      step();
    end
    bus.in_valid = 1'b0;
    step();
    step();
    check("wrap_cnt", 32'(beat_cnt), 32'd1);

    // Asynchronous reset mid-stream.
    drive(8'hF0, CH, 2'd2, 2'b00);
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data", 32'(bus.out_data), 32'h00);
    check("arst_cnt", 32'(beat_cnt), 32'd0);
    check("arst_sel_err", 32'(sel_err), 32'd0);
    bus.in_valid = 1'b0;
    exp_q.delete();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_idle", 32'(bus.out_valid), 32'd0);
    end
    drive(8'hF0, CH, 2'd2, 2'b00);
    step();
    bus.in_valid = 1'b0;
    step();
    check("post_rst_data", 32'(bus.out_data), 32'h30);
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    step();
    check("post_rst_cnt", 32'(beat_cnt), 32'd1);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
